tank_render_scheduler: RTL
==========================

Name: tank_render_scheduler

Overview:
- Sequences the shared sprite renderer (tank erase/draw engine) between the two tank controllers.
- Each tank controller raises a redraw request carrying its old position, new position and direction; the scheduler grants one tank at a time round-robin.
- For the granted tank it issues an erase at the old position, waits for the renderer's done, issues a draw at the new position, waits for done, then acknowledges.
- Sits between the two tank movement FSMs and the renderer; the renderer's VGA write outputs pass through untouched.

Parameters:
ENABLE_HOLD, 2, cycles the renderer draw/erase enable is held high per command (renderer samples the enable twice: idle, then colour select).
TIMEOUT_CYCLES, 1023, max cycles spent in a wait state before aborting; counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
iCLOCK_50  in  1  system clock
iresetn  in  1  reset, asynchronous, active-low
ireq1, ireq2  in  1  level redraw request from tank 1 / tank 2, held until matching ack
iskip_erase1, iskip_erase2  in  1  sampled at grant; 1 = draw only (spawn)
iold_x1, iold_x2  in  9  old X position
iold_y1, iold_y2  in  8  old Y position
inew_x1, inew_x2  in  9  new X position
inew_y1, inew_y2  in  8  new Y position
idir1, idir2  in  2  direction: 00 up, 01 down, 10 left, 11 right
irenderDone  in  1  renderer done pulse
odrawEn, oeraseEn  out  1  renderer command enables
ox_pos  out  9  renderer X origin
oy_pos  out  8  renderer Y origin
oTankDirection1, oTankDirection2  out  2  renderer direction selects
oTank1Enable, oTank2Enable  out  1  renderer sprite select, one-hot or zero
oack1, oack2  out  1  one-cycle completion pulse per tank
obusy  out  1  high in every state except IDLE
oerror  out  1  one-cycle pulse on timeout abort

Behaviour:
- All outputs are registered.
- Reset (async, any state): state IDLE, all outputs 0, last_grant=2 (so tank 1 wins the first tie), counters 0.
- States: IDLE, ERASE_REQ, ERASE_WAIT, DRAW_REQ, DRAW_WAIT, ACK.
- IDLE:
  - No request: remain in IDLE.
  - One request: grant that tank.
  - Both requests: grant the tank not equal to last_grant, then update last_grant.
  - At grant, latch old/new X/Y, dir and skip_erase of the granted tank.
  - Set the granted oTankNEnable=1 and oTankDirectionN=dir.
  - Next state: ERASE_REQ, or DRAW_REQ if skip_erase=1.
- ERASE_REQ: oeraseEn=1, ox_pos/oy_pos = latched old position, for exactly ENABLE_HOLD cycles. Then oeraseEn=0 and go to ERASE_WAIT.
- ERASE_WAIT: on irenderDone go to DRAW_REQ. The timeout counter runs.
- DRAW_REQ: odrawEn=1, ox_pos/oy_pos = latched new position, for exactly ENABLE_HOLD cycles. Then go to DRAW_WAIT.
- DRAW_WAIT: on irenderDone go to ACK.
- ACK: oackN=1 for one cycle. Tank enable, position and direction are cleared to 0. Next state: IDLE.
- The requester must drop its request on the edge where it samples ack=1. A request still high in IDLE is serviced again.
- odrawEn and oeraseEn are never high simultaneously. Enables are never high in a WAIT state, so the renderer cannot retrigger when done arrives.
- irenderDone is ignored outside the WAIT states.
- Latched operands stay stable from grant to ACK. Input changes during service have no effect.
- The tank enable and direction stay constant from grant through the DRAW_WAIT exit.
- Timeout:
  - The counter clears on entry to each WAIT state.
  - When it reaches TIMEOUT_CYCLES without done: oerror pulses once, no ack is issued, all renderer outputs clear, state goes to IDLE.
  - last_grant still updates, so the other tank is not starved.
- A request deasserting before grant is simply dropped. A request deasserting after grant does not abort the sequence.

Test Plan:
- Single request: ireq1=1, old=(10,20), new=(12,20), dir=11, done returned 5 cycles after each enable falls.
  - Required: oeraseEn high 2 cycles with ox=10, oy=20, oTank1Enable=1, oTankDirection1=11.
  - Then odrawEn high 2 cycles with ox=12, oy=20.
  - oack1 pulses once; obusy falls in the following cycle.
- Tie and fairness: ireq1 and ireq2 rise in the same cycle after reset.
  - Required: tank 1 is serviced first, then tank 2.
  - Repeat the tie: tank 2 is serviced first.
  - Acks strictly alternate; oTank1Enable and oTank2Enable are never both 1.
- Skip erase: ireq2=1, iskip_erase2=1, new=(100,50).
  - Required: no oeraseEn pulse; odrawEn with ox=100, oy=50; then oack2.
- Spurious and changing inputs:
  - irenderDone pulsed in IDLE and during ERASE_REQ: ignored.
  - inew_x1 changed to 200 mid-erase: the draw still uses the value latched at grant.
- Timeout: renderer never returns done, TIMEOUT_CYCLES=15.
  - Required: oerror pulses 15 cycles after entering ERASE_WAIT; no ack; outputs return to 0; the next pending request is granted.
- Async reset: assert iresetn=0 mid DRAW_REQ, between clock edges.
  - Required: odrawEn, oTank1Enable and obusy go to 0 immediately, without waiting for a clock edge.
  - After release, a fresh ireq1 runs the full erase/draw sequence.

Source files
------------

// File: rtl/tank_render_scheduler.sv
// tank_render_scheduler
// Arbitrates the shared tank sprite renderer between two tank controllers.
// A granted tank gets an erase at its old position, then a draw at its new
// position, each followed by a wait for the renderer's done pulse, and
// finally a one-cycle ack. Every output is a register.
//
// Ports:
//   iCLOCK_50, iresetn          clock, async active-low reset
//   ireqN, iskip_eraseN         level request / draw-only flag per tank
//   iold_xN/yN, inew_xN/yN      old and new sprite origin per tank
//   idirN                       sprite direction per tank
//   irenderDone                 renderer completion pulse
//   odrawEn, oeraseEn           renderer command enables
//   ox_pos, oy_pos              renderer origin
//   oTankDirectionN             renderer direction selects
//   oTankNEnable                renderer sprite select (one-hot or zero)
//   oackN                       completion pulse per tank
//   obusy                       high whenever not idle
//   oerror                      pulse on wait timeout
module tank_render_scheduler #(
  parameter int unsigned ENABLE_HOLD    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic       iCLOCK_50,
  input  logic       iresetn,
  input  logic       ireq1,
  input  logic       ireq2,
  input  logic       iskip_erase1,
  input  logic       iskip_erase2,
  input  logic [8:0] iold_x1,
  input  logic [8:0] iold_x2,
  input  logic [7:0] iold_y1,
  input  logic [7:0] iold_y2,
  input  logic [8:0] inew_x1,
  input  logic [8:0] inew_x2,
  input  logic [7:0] inew_y1,
  input  logic [7:0] inew_y2,
  input  logic [1:0] idir1,
  input  logic [1:0] idir2,
  input  logic       irenderDone,
  output logic       odrawEn,
  output logic       oeraseEn,
  output logic [8:0] ox_pos,
  output logic [7:0] oy_pos,
  output logic [1:0] oTankDirection1,
  output logic [1:0] oTankDirection2,
  output logic       oTank1Enable,
  output logic       oTank2Enable,
  output logic       oack1,
  output logic       oack2,
  output logic       obusy,
  output logic       oerror
);

  localparam int unsigned HoldW = $clog2(ENABLE_HOLD + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle, StEraseReq, StEraseWait, StDrawReq, StDrawWait, StAck
  } state_e;

  state_e            state_q, state_d;
  logic              last2_q, last2_d;   // 1: tank 2 was granted most recently
  logic              svc2_q, svc2_d;     // 1: tank 2 is being serviced
  logic [8:0]        new_x_q, new_x_d;
  logic [7:0]        new_y_q, new_y_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              draw_q, draw_d, erase_q, erase_d;
  logic [8:0]        x_q, x_d;
  logic [7:0]        y_q, y_d;
  logic [1:0]        dir1_q, dir1_d, dir2_q, dir2_d;
  logic              en1_q, en1_d, en2_q, en2_d;
  logic              ack1_q, ack1_d, ack2_q, ack2_d;
  logic              busy_q, busy_d, err_q, err_d;

  logic              pick2, abort;
  logic [8:0]        sel_old_x, sel_new_x;
  logic [7:0]        sel_old_y, sel_new_y;
  logic              sel_skip;

  // Round robin: a tie goes to the tank that was not granted last. Every
  // grant moves last_grant, including one that later times out.
  always_comb begin
    pick2     = (ireq1 && ireq2) ? !last2_q : ireq2;
    sel_old_x = pick2 ? iold_x2 : iold_x1;
    sel_old_y = pick2 ? iold_y2 : iold_y1;
    sel_new_x = pick2 ? inew_x2 : inew_x1;
    sel_new_y = pick2 ? inew_y2 : inew_y1;
    sel_skip  = pick2 ? iskip_erase2 : iskip_erase1;
  end

  always_comb begin
    state_d = state_q;
    last2_d = last2_q;
    svc2_d  = svc2_q;
    new_x_d = new_x_q;
    new_y_d = new_y_q;
    hold_d  = hold_q;
    tmo_d   = tmo_q;
    draw_d  = draw_q;
    erase_d = erase_q;
    x_d     = x_q;
    y_d     = y_q;
    dir1_d  = dir1_q;
    dir2_d  = dir2_q;
    en1_d   = en1_q;
    en2_d   = en2_q;
    ack1_d  = 1'b0;
    ack2_d  = 1'b0;
    err_d   = 1'b0;
    abort   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ireq1 || ireq2) begin
          last2_d = pick2;
          svc2_d  = pick2;
          new_x_d = sel_new_x;
          new_y_d = sel_new_y;
          en1_d   = !pick2;
          en2_d   = pick2;
          if (pick2) dir2_d = idir2;
          else       dir1_d = idir1;
          hold_d  = '0;
          // The old position is only needed now, so it goes straight out.
          if (sel_skip) begin
            state_d = StDrawReq;
            draw_d  = 1'b1;
            x_d     = sel_new_x;
            y_d     = sel_new_y;
          end else begin
            state_d = StEraseReq;
            erase_d = 1'b1;
            x_d     = sel_old_x;
            y_d     = sel_old_y;
          end
        end
      end
      StEraseReq: begin
        if (hold_q == HoldW'(ENABLE_HOLD - 1)) begin
          erase_d = 1'b0;
          tmo_d   = '0;
          state_d = StEraseWait;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StEraseWait: begin
        if (irenderDone) begin
          state_d = StDrawReq;
          draw_d  = 1'b1;
          x_d     = new_x_q;
          y_d     = new_y_q;
          hold_d  = '0;
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StDrawReq: begin
        if (hold_q == HoldW'(ENABLE_HOLD - 1)) begin
          draw_d  = 1'b0;
          tmo_d   = '0;
          state_d = StDrawWait;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StDrawWait: begin
        if (irenderDone) begin
          state_d = StAck;
          ack1_d  = !svc2_q;
          ack2_d  = svc2_q;
          x_d     = '0;
          y_d     = '0;
          dir1_d  = '0;
          dir2_d  = '0;
          en1_d   = 1'b0;
          en2_d   = 1'b0;
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
      err_d   = 1'b1;
      draw_d  = 1'b0;
      erase_d = 1'b0;
      x_d     = '0;
      y_d     = '0;
      dir1_d  = '0;
      dir2_d  = '0;
      en1_d   = 1'b0;
      en2_d   = 1'b0;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge iCLOCK_50 or negedge iresetn) begin
    if (!iresetn) begin
      state_q <= StIdle;
      last2_q <= 1'b1;
      svc2_q  <= 1'b0;
      new_x_q <= '0;
      new_y_q <= '0;
      hold_q  <= '0;
      tmo_q   <= '0;
      draw_q  <= 1'b0;
      erase_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      dir1_q  <= '0;
      dir2_q  <= '0;
      en1_q   <= 1'b0;
      en2_q   <= 1'b0;
      ack1_q  <= 1'b0;
      ack2_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last2_q <= last2_d;
      svc2_q  <= svc2_d;
      new_x_q <= new_x_d;
      new_y_q <= new_y_d;
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
      draw_q  <= draw_d;
      erase_q <= erase_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir1_q  <= dir1_d;
      dir2_q  <= dir2_d;
      en1_q   <= en1_d;
      en2_q   <= en2_d;
      ack1_q  <= ack1_d;
      ack2_q  <= ack2_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign odrawEn         = draw_q;
  assign oeraseEn        = erase_q;
  assign ox_pos          = x_q;
  assign oy_pos          = y_q;
  assign oTankDirection1 = dir1_q;
  assign oTankDirection2 = dir2_q;
  assign oTank1Enable    = en1_q;
  assign oTank2Enable    = en2_q;
  assign oack1           = ack1_q;
  assign oack2           = ack2_q;
  assign obusy           = busy_q;
  assign oerror          = err_q;

endmodule
